fifo_stream_buf: RTL and testbench

- Parametrised synchronous FIFO with a manual mode and an automatic prefill/stream mode.
- Generalises the lab FIFO:
  - any DEPTH of 2 or more, with occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow/underflow flags
  - registered read data with a valid strobe
- Auto mode uses a prefill/wait/stream state machine with parametrised level and delay.
- Sits between a sample source (switches/ADC) and a display/output consumer on the board clock.

---
 rtl/fifo_stream_pkg.sv | 21 ++
 rtl/fifo_wait_timer.sv | 36 +++
 rtl/fifo_stream_buf.sv | 174 +++++++++++++++++
 tb/tb_fifo_stream_buf.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the prefill/stream FIFO: FSM state encodings,
// pointer wrap and occupancy-counter width.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_e;

  function automatic int unsigned cntWidth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers wrap at any depth, not only powers of two
  function automatic logic [31:0] wrapNext(input logic [31:0] ptr, input int unsigned depth);
    return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wait_timer.sv
// Saturating cycle timer for the WAIT state; done marks the last WAIT cycle.
// WAIT_CYCLES=0 keeps done high so WAIT lasts a single cycle.
module fifo_wait_timer #(
  parameter int WAIT_CYCLES = 25_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int TW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] LAST = TW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] SAT  = TW'(WAIT_CYCLES);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr)
      timer_d = '0;
    else if (en && (timer_q != SAT))
      timer_d = timer_q + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST)
      timer_q <= '0;
    else
      timer_q <= timer_d;
  end

  assign done = (WAIT_CYCLES == 0) || (timer_q == LAST);

endmodule

// File: rtl/fifo_stream_buf.sv
// Parametrised synchronous FIFO with manual mode and auto prefill/wait/stream mode.
// Define FIFO_SCRUB_EN to zero each slot as it is consumed.
module fifo_stream_buf
  import fifo_stream_pkg::*;
#(
  parameter int WL          = 10,
  parameter int DEPTH       = 4,
  parameter int AF_LEVEL    = DEPTH - 1,
  parameter int AE_LEVEL    = 1,
  parameter int FILL_LEVEL  = DEPTH,
  parameter int WAIT_CYCLES = 25_000_000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       wReq,
  input  logic                       rReq,
  input  logic                       auto,
  input  logic                       err_clr,
  input  logic [WL-1:0]              din,
  output logic [WL-1:0]              dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       ovf,
  output logic                       udf,
  output logic [1:0]                 state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] FILL_C  = CNT_W'(FILL_LEVEL);

  state_e state_q, state_d;

  logic [WL-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wPtr_q, wPtr_d, rPtr_q, rPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [WL-1:0]    dout_q, dout_d;
  logic             valid_q;

  logic rdReqInt, udfArm, timerClr, timerEn, timerDone;
  logic rdEn, wrEn, ovfEvt, udfEvt;

  fifo_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (timerClr),
    .en   (timerEn),
    .done (timerDone)
  );

  always_ff @(posedge CLK) begin
    if (RST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (auto) state_d = FILL;
      FILL:    if (!auto) state_d = IDLE; else if (count_q >= FILL_C) state_d = WAIT;
      WAIT:    if (!auto) state_d = IDLE; else if (timerDone) state_d = STREAM;
      STREAM:  if (!auto) state_d = IDLE; else if (empty_q) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  // Only manual-mode reads can underflow; a STREAM underrun just rebuffers
  always_comb begin
    rdReqInt = 1'b0;
    udfArm   = 1'b0;
    timerClr = 1'b1;
    timerEn  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdReqInt = rReq;
        udfArm   = rReq;
      end
      WAIT: begin
        timerClr = 1'b0;
        timerEn  = 1'b1;
      end
      STREAM:  rdReqInt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rdEn   = rdReqInt && !empty_q;
    wrEn   = wReq && (!full_q || rdEn);
    ovfEvt = wReq && full_q && !rdEn;
    udfEvt = udfArm && empty_q;

    wPtr_d = wrEn ? PTR_W'(wrapNext(32'(wPtr_q), DEPTH)) : wPtr_q;
    rPtr_d = rdEn ? PTR_W'(wrapNext(32'(rPtr_q), DEPTH)) : rPtr_q;

    count_d = count_q;
    if (wrEn && !rdEn)
      count_d = count_q + CNT_W'(1);
    else if (rdEn && !wrEn)
      count_d = count_q - CNT_W'(1);

    // Flags are derived from the next count so they register alongside it
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    ovf_d  = ovfEvt || (ovf_q && !err_clr);
    udf_d  = udfEvt || (udf_q && !err_clr);
    dout_d = rdEn ? mem_q[rPtr_q] : dout_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wPtr_q  <= '0;
      rPtr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      wPtr_q  <= wPtr_d;
      rPtr_q  <= rPtr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dout_q  <= dout_d;
      valid_q <= rdEn;
    end
  end

  // Storage is never reset; the later write wins when both hit one slot
  always_ff @(posedge CLK) begin
`ifdef FIFO_SCRUB_EN
    if (!RST && rdEn)
      mem_q[rPtr_q] <= '0;
`endif
    if (!RST && wrEn)
      mem_q[wPtr_q] <= din;
  end

  assign dout         = dout_q;
  assign dout_valid   = valid_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_fifo_stream_buf.sv
// Directed bench for fifo_stream_buf: a DEPTH=4 instance for manual/auto modes
// and a DEPTH=5 instance for pointer wrap and programmable almost flags.
module tb_fifo_stream_buf;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic       wReq = 1'b0, rReq = 1'b0, autoMode = 1'b0, errClr = 1'b0;
  logic [9:0] din = '0;
  logic [9:0] dout;
  logic [2:0] count;
  logic [1:0] state;
  logic       doutValid, full, empty, almostFull, almostEmpty, ovf, udf;

  logic       w1Req = 1'b0, r1Req = 1'b0;
  logic [9:0] din1 = '0;
  logic [9:0] dout1;
  logic [2:0] count1;
  logic [1:0] state1;
  logic       doutValid1, full1, empty1, almostFull1, almostEmpty1, ovf1, udf1;

  int checks = 0;
  int errors = 0;

  fifo_stream_buf #(.WL(10), .DEPTH(4), .WAIT_CYCLES(8)) u0 (
    .CLK(CLK), .RST(RST), .wReq(wReq), .rReq(rReq), .auto(autoMode), .err_clr(errClr),
    .din(din), .dout(dout), .dout_valid(doutValid), .count(count), .full(full),
    .empty(empty), .almost_full(almostFull), .almost_empty(almostEmpty),
    .ovf(ovf), .udf(udf), .state(state)
  );

  fifo_stream_buf #(.WL(10), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .WAIT_CYCLES(8)) u1 (
    .CLK(CLK), .RST(RST), .wReq(w1Req), .rReq(r1Req), .auto(1'b0), .err_clr(1'b0),
    .din(din1), .dout(dout1), .dout_valid(doutValid1), .count(count1), .full(full1),
    .empty(empty1), .almost_full(almostFull1), .almost_empty(almostEmpty1),
    .ovf(ovf1), .udf(udf1), .state(state1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic r, input logic [9:0] d);
    wReq = w;
    rReq = r;
    din  = d;
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] expRd [4];
    logic [9:0] model [$];
    logic [9:0] want;

    tick();
    tick();
    checkOutput("rst count", 32'(count), 0);
    checkOutput("rst empty", 32'(empty), 1);
    checkOutput("rst full", 32'(full), 0);
    checkOutput("rst af", 32'(almostFull), 0);
    checkOutput("rst ae", 32'(almostEmpty), 1);
    checkOutput("rst ovf", 32'(ovf), 0);
    checkOutput("rst udf", 32'(udf), 0);
    checkOutput("rst dout", 32'(dout), 0);
    checkOutput("rst valid", 32'(doutValid), 0);
    checkOutput("rst state", 32'(state), 0);
    RST = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 10'(i));
      checkOutput("wr count", 32'(count), 32'(i));
    end
    checkOutput("full after 4", 32'(full), 1);
    checkOutput("af after 4", 32'(almostFull), 1);
    checkOutput("ae after 4", 32'(almostEmpty), 0);
    applyStimulus(1'b1, 1'b0, 10'h005);
    checkOutput("ovf on 5th", 32'(ovf), 1);
    checkOutput("count on 5th", 32'(count), 4);

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 10'h000);
      checkOutput("rd dout", 32'(dout), 32'(i));
      checkOutput("rd valid", 32'(doutValid), 1);
      checkOutput("rd count", 32'(count), 32'(4 - i));
    end
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("idle valid", 32'(doutValid), 0);
    checkOutput("empty after drain", 32'(empty), 1);
    checkOutput("ovf sticky", 32'(ovf), 1);

    applyStimulus(1'b0, 1'b1, 10'h000);
    checkOutput("udf set", 32'(udf), 1);
    checkOutput("udf valid", 32'(doutValid), 0);
    checkOutput("udf dout held", 32'(dout), 32'h004);
    errClr = 1'b1;
    applyStimulus(1'b0, 1'b0, 10'h000);
    errClr = 1'b0;
    checkOutput("clr udf", 32'(udf), 0);
    checkOutput("clr ovf", 32'(ovf), 0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 10'(16 + i));
    applyStimulus(1'b1, 1'b1, 10'h3FF);
    checkOutput("full rw dout", 32'(dout), 32'h010);
    checkOutput("full rw count", 32'(count), 4);
    checkOutput("full rw ovf", 32'(ovf), 0);
    expRd[0] = 10'h011; expRd[1] = 10'h012; expRd[2] = 10'h013; expRd[3] = 10'h3FF;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 10'h000);
      checkOutput("full rw order", 32'(dout), 32'(expRd[i]));
    end

    applyStimulus(1'b1, 1'b1, 10'h055);
    checkOutput("empty rw count", 32'(count), 1);
    checkOutput("empty rw udf", 32'(udf), 1);
    checkOutput("empty rw valid", 32'(doutValid), 0);
    applyStimulus(1'b0, 1'b1, 10'h000);
    checkOutput("empty rw data", 32'(dout), 32'h055);
    errClr = 1'b1;
    applyStimulus(1'b0, 1'b1, 10'h000);
    checkOutput("set beats clr", 32'(udf), 1);
    applyStimulus(1'b0, 1'b0, 10'h000);
    errClr = 1'b0;
    checkOutput("clr after set", 32'(udf), 0);

    // Auto mode: prefill, wait 8 cycles, stream
    autoMode = 1'b1;
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("auto fill", 32'(state), 1);
    applyStimulus(1'b1, 1'b1, 10'h021);
    checkOutput("fill no read", 32'(doutValid), 0);
    checkOutput("fill count", 32'(count), 1);
    for (int i = 2; i <= 4; i++) applyStimulus(1'b1, 1'b0, 10'(32 + i));
    checkOutput("fill at 4", 32'(state), 1);
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("enter wait", 32'(state), 2);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 10'h000);
      checkOutput("in wait", 32'(state), 2);
    end
    checkOutput("wait count", 32'(count), 4);
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("enter stream", 32'(state), 3);
    checkOutput("stream first valid", 32'(doutValid), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 10'h000);
      checkOutput("stream dout", 32'(dout), 32'(33 + i));
      checkOutput("stream count", 32'(count), 32'(3 - i));
    end
    checkOutput("stream empty", 32'(state), 3);
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("rebuffer", 32'(state), 1);
    checkOutput("underrun no udf", 32'(udf), 0);
    checkOutput("underrun valid", 32'(doutValid), 0);

    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 10'(48 + i));
    applyStimulus(1'b0, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("second wait", 32'(state), 2);
    autoMode = 1'b0;
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("abort to idle", 32'(state), 0);
    checkOutput("abort count", 32'(count), 4);

    autoMode = 1'b1;
    applyStimulus(1'b0, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("rewait", 32'(state), 2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("restream", 32'(state), 3);
    applyStimulus(1'b0, 1'b0, 10'h000);
    checkOutput("restream dout", 32'(dout), 32'h031);
    checkOutput("restream count", 32'(count), 3);

    RST = 1'b1;
    applyStimulus(1'b1, 1'b0, 10'h1AA);
    checkOutput("midrst state", 32'(state), 0);
    checkOutput("midrst count", 32'(count), 0);
    checkOutput("midrst empty", 32'(empty), 1);
    checkOutput("midrst ae", 32'(almostEmpty), 1);
    checkOutput("midrst dout", 32'(dout), 0);
    checkOutput("midrst valid", 32'(doutValid), 0);
`ifdef FIFO_SCRUB_EN
    checkOutput("scrubbed slot", 32'(u0.mem_q[2]), 32'h000);
`else
    checkOutput("kept slot", 32'(u0.mem_q[2]), 32'h031);
`endif
    checkOutput("unread slot", 32'(u0.mem_q[3]), 32'h032);
    RST = 1'b0;
    autoMode = 1'b0;
    wReq = 1'b0;

    // DEPTH=5 instance: AF_LEVEL=3, AE_LEVEL=2
    for (int i = 0; i < 3; i++) begin
      w1Req = 1'b1;
      din1  = 10'(256 + i);
      model.push_back(din1);
      tick();
    end
    w1Req = 1'b0;
    checkOutput("d5 count", 32'(count1), 3);
    checkOutput("d5 af at 3", 32'(almostFull1), 1);
    checkOutput("d5 ae at 3", 32'(almostEmpty1), 0);
    for (int i = 0; i < 12; i++) begin
      w1Req = 1'b1;
      r1Req = 1'b1;
      din1  = 10'(512 + i);
      want  = model.pop_front();
      model.push_back(din1);
      tick();
      checkOutput("d5 pair dout", 32'(dout1), 32'(want));
      checkOutput("d5 pair count", 32'(count1), 3);
    end
    w1Req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r1Req = 1'b1;
      want  = model.pop_front();
      tick();
      checkOutput("d5 drain dout", 32'(dout1), 32'(want));
      if (i == 0) begin
        checkOutput("d5 af at 2", 32'(almostFull1), 0);
        checkOutput("d5 ae at 2", 32'(almostEmpty1), 1);
      end
    end
    r1Req = 1'b0;
    tick();
    checkOutput("d5 empty", 32'(empty1), 1);
    checkOutput("d5 last", 32'(dout1), 32'h20B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
